// File: rtl/tt_serial_pkg.sv
// Shared constants and state encoding for the
// bit-serial subtractor.
package tt_serial_pkg;

  localparam int WORD_W  = 8;
  localparam int COUNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor:
// d = a - b - bin, bout set when the bit underflows.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_serial_sub.sv
// Bit-serial A-B subtractor, LSB first, one bit per
// accepted cycle; result shifted in from the top.
module tt_um_serial_sub
  import tt_serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic a;
  logic b;
  logic bit_valid;
  logic start;

  assign a         = ui_in[0];
  assign b         = ui_in[1];
  assign bit_valid = ui_in[2];
  assign start     = ui_in[3];

  logic unused;
  assign unused = ^{uio_in, ui_in[7:4]};

  state_t state;
  state_t state_next;

  logic               borrow_q;
  logic               diff_q;
  logic [COUNT_W-1:0] count_q;
  logic [WORD_W-1:0]  result_q;

  logic d;
  logic bout;
  logic busy;
  logic done;
  logic clear;
  logic accept;
  logic last_bit;

  fs_cell u_fs (
    .a    (a),
    .b    (b),
    .bin  (borrow_q),
    .d    (d),
    .bout (bout)
  );

  assign last_bit = (count_q == COUNT_W'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start)
          state_next = RUN;
        else if (bit_valid && last_bit)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // start in RUN aborts the word and wins over bit_valid
  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    clear  = start &&
             ((state == IDLE) || (state == RUN));
    accept = (state == RUN) && bit_valid && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_q <= 1'b0;
      diff_q   <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else if (ena) begin
      if (clear) begin
        borrow_q <= 1'b0;
        diff_q   <= 1'b0;
        count_q  <= '0;
        result_q <= '0;
      end else if (accept) begin
        borrow_q <= bout;
        diff_q   <= d;
        count_q  <= count_q + COUNT_W'(1);
        result_q <= {d, result_q[WORD_W-1:1]};
      end
    end
  end

  assign uo_out  = {1'b0, count_q, done, busy,
                    borrow_q, diff_q};
  assign uio_out = result_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Scoreboard bench for tt_um_serial_sub: words are
// modelled as plain integer subtraction.
module tb_tt_um_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];

  always #5 clk = ~clk;

  tt_um_serial_sub dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic chk(string name,
                     logic [15:0] act,
                     logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, act, exp);
    end
  endtask

  // {uo_out, uio_out} after k bits of A-B
  function automatic logic [15:0] model(
    int a, int b, int k, bit busy, bit done);
    int dd, m, res, bo, db;
    dd  = (a - b) & 255;
    m   = (1 << k) - 1;
    res = ((dd & m) << (8 - k)) & 255;
    bo  = ((a & m) < (b & m)) ? 1 : 0;
    db  = (k == 0) ? 0 : ((dd >> (k - 1)) & 1);
    return {1'b0, 3'(k & 7), done, busy,
            1'(bo), 1'(db), 8'(res)};
  endfunction

  function automatic logic [8:0] word_exp(
    int a, int b);
    return {1'(a < b), 8'((a - b) & 255)};
  endfunction

  task automatic drive(bit a, bit b, bit v, bit s);
    ui_in = {4'($urandom), s, v, b, a};
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic start_word;
    drive(1'($urandom), 1'($urandom),
          1'($urandom), 1'b1);
    cyc;
  endtask

  task automatic send_bits(int a, int b,
                           int from, int to,
                           int gmin, int gmax,
                           string tag);
    for (int i = from; i < to; i++) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        chk({tag, " gap"}, {uo_out, uio_out},
            model(a, b, i, 1'b1, 1'b0));
        drive(1'($urandom), 1'($urandom),
              1'b0, 1'b0);
        cyc;
      end
      chk({tag, " bit"}, {uo_out, uio_out},
          model(a, b, i, 1'b1, 1'b0));
      drive(1'((a >> i) & 1), 1'((b >> i) & 1),
            1'b1, 1'b0);
      cyc;
    end
  endtask

  task automatic finish_word(int a, int b,
                             string tag);
    chk({tag, " done"}, {uo_out, uio_out},
        model(a, b, 8, 1'b0, 1'b1));
    drive(1'($urandom), 1'($urandom),
          1'($urandom), 1'b1);
    cyc;
    chk({tag, " idle"}, {uo_out, uio_out},
        model(a, b, 8, 1'b0, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cyc;
    chk({tag, " hold"}, {uo_out, uio_out},
        model(a, b, 8, 1'b0, 1'b0));
  endtask

  task automatic run_word(int a, int b,
                          int gmin, int gmax,
                          string tag);
    sb_q.push_back(word_exp(a, b));
    start_word;
    send_bits(a, b, 0, 8, gmin, gmax, tag);
    finish_word(a, b, tag);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uo_out[3] === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon unexpected done %h %h",
                   uo_out, uio_out);
        end else begin
          chk("mon word", {7'd0, uo_out[1], uio_out},
              {7'd0, sb_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int a, b;
    ena = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc;
    chk("reset", {uo_out, uio_out}, 16'h0000);
    chk("oe", {8'h00, uio_oe}, 16'h00FF);
    rst_n = 1'b1;

    run_word(8'h05, 8'h03, 0, 0, "w05_03");
    run_word(8'h03, 8'h05, 1, 3, "w03_05");
    run_word(8'h80, 8'h80, 0, 1, "w80_80");
    run_word(8'h00, 8'h01, 0, 1, "w00_01");

    start_word;
    send_bits(8'hA5, 8'h3C, 0, 4, 0, 1, "abort");
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    cyc;
    chk("abort clr", {uo_out, uio_out},
        model(0, 0, 0, 1'b1, 1'b0));
    sb_q.push_back(word_exp(8'h10, 8'h01));
    send_bits(8'h10, 8'h01, 0, 8, 0, 1, "w10_01");
    finish_word(8'h10, 8'h01, "w10_01");

    start_word;
    send_bits(8'h5A, 8'h21, 0, 5, 0, 0, "prerst");
    rst_n = 1'b0;
    #1;
    chk("async rst", {uo_out, uio_out}, 16'h0000);
    cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom),
            1'b1, 1'b0);
      cyc;
      chk("no start", {uo_out, uio_out}, 16'h0000);
    end
    run_word(8'h5A, 8'h21, 0, 1, "postrst");

    a = int'($urandom_range(255, 0));
    b = int'($urandom_range(255, 0));
    sb_q.push_back(word_exp(a, b));
    start_word;
    send_bits(a, b, 0, 3, 0, 1, "frz");
    ena = 1'b0;
    repeat (10) begin
      drive(1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      cyc;
      chk("frozen", {uo_out, uio_out},
          model(a, b, 3, 1'b1, 1'b0));
    end
    ena = 1'b1;
    send_bits(a, b, 3, 8, 0, 1, "frz");
    finish_word(a, b, "frz");

    repeat (20) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 0));
      run_word(a, b, 0, 2, "rand");
    end

    repeat (3) cyc;
    chk("sb empty", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_sub.md
TT_UM_SERIAL_SUB -- requirements
Module: tt_um_serial_sub

Interface
REQ-001 Parameter: none; word width fixed at 8 bits (package constant WORD_W = 8).
REQ-002 clk  input  1  single design clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  design enable; 0 freezes all state.
REQ-005 ui_in  input  8  [0]=minuend bit a, [1]=subtrahend bit b, [2]=bit_valid, [3]=start, [7:4] ignored.
REQ-006 uo_out  output  8  [0]=last difference bit, [1]=borrow, [2]=busy, [3]=done, [6:4]=bit count, [7]=0.
REQ-007 uio_in  input  8  unused, ignored.
REQ-008 uio_out  output  8  assembled 8-bit difference register.
REQ-009 uio_oe  output  8  constant 8'hFF.

Function
REQ-010 Bit-serial subtractor computing A-B, LSB first, one bit per accepted cycle; counterpart of the existing half adder.
REQ-011 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-012 IDLE: start=1 -> RUN; borrow, bit count, difference register and diff bit cleared; bit_valid in that same cycle ignored.
REQ-013 RUN: bit_valid=1 accepts a bit; bit_valid=0 holds all state (gaps allowed, unbounded).
REQ-014 Per accepted bit: d = a^b^borrow; borrow_next = (~a&b) | (~(a^b)&borrow); result <= {d, result[7:1]}; uo_out[0] <= d; count++.
REQ-015 Accepted bit with count==7 -> DONE next cycle; count wraps to 0.
REQ-016 start=1 in RUN takes priority over bit_valid: word aborted, all cleared as REQ-012, stays RUN.
REQ-017 DONE lasts exactly one cycle, then IDLE; start in DONE ignored.
REQ-018 busy (uo_out[2]) = 1 iff state is RUN; done (uo_out[3]) = 1 iff state is DONE (one-cycle pulse).
REQ-019 uio_out and uo_out[1] hold final difference and final borrow from DONE until next start; borrow=1 means A<B (unsigned).
REQ-020 Latency: result valid on uio_out in the cycle done=1, one cycle after eighth accepted bit.
REQ-021 ena=0: no state, counter, or output register changes regardless of other inputs; resumes unchanged when ena=1.
REQ-022 All outputs registered or constant; no combinational path from ui_in to uo_out/uio_out.

Reset
REQ-023 rst_n=0 asynchronously forces state IDLE, borrow 0, count 0, result 8'h00, diff bit 0; uo_out=8'h00, uio_out=8'h00.
REQ-024 Reset mid-word discards partial word; first post-reset start begins a clean word.
REQ-025 Reset deassertion needs no further sequencing; start accepted on first clock edge with rst_n=1.

Structure
REQ-026 Shared package tt_serial_pkg holds WORD_W, COUNT_W=3, and state enumeration (IDLE, RUN, DONE).
REQ-027 One sub-module fs_cell: combinational full subtractor (a, b, bin -> d, bout); top instantiates it once with the borrow flop.
REQ-028 Implementation target 120-400 RTL lines including package and fs_cell.

Verification
REQ-029 Reset, start, bits of A=0x05, B=0x03 LSB first, continuous valid -> done pulse 1 cycle after 8th bit, uio_out=0x02, borrow=0.
REQ-030 A=0x03, B=0x05 with random 1-3 cycle valid gaps -> uio_out=0xFE, borrow=1, busy high throughout, count 0..7 then 0.
REQ-031 A=0x80, B=0x80 -> uio_out=0x00, borrow=0; then A=0x00, B=0x01 -> 0xFF, borrow=1.
REQ-032 start asserted with bit_valid after 4 bits of a word, then A=0x10, B=0x01 -> first word discarded, uio_out=0x0F, count restarted at 0.
REQ-033 rst_n low for 1 cycle after 5 bits -> all outputs 0 immediately (asynchronous), state IDLE; bits without start ignored.
REQ-034 ena=0 for 10 cycles mid-word while toggling a/b/valid/start -> outputs frozen; after ena=1, completing word gives correct difference.
